serial_pattern_detector: RTL

Downstream consumer of the D flip-flop stage. Samples the registered serial bit stream (the flip-flop Q output) and detects a fixed bit pattern, with overlapping matches allowed. Produces a one-cycle registered match pulse, a saturating match counter, and the shift history for debug and display. This is the first sequential stage that turns the flip-flop output into an event stream.

---
 rtl/serial_pattern_detector.sv | 63 ++++++
 1 files changed

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: samples the registered bit stream, flags overlapping
// matches of PATTERN with a one-cycle registered pulse and keeps a saturating match count.
module serial_pattern_detector #(
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
   parameter int                   CNT_W     = 8
) (
   input  logic                 CLK,
   input  logic                 ClrN,
   input  logic                 D_in,
   input  logic                 En,
   input  logic                 Clr_cnt,
   output logic                 Match,
   output logic [CNT_W-1:0]     Match_cnt,
   output logic [PATTERN_W-1:0] Shift_reg,
   output logic                 Valid
);

   localparam int                FILL_W   = $clog2(PATTERN_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   logic [FILL_W-1:0]    fill_q;
   logic [FILL_W-1:0]    fill_next;
   logic [PATTERN_W-1:0] shift_next;
   logic                 hit;

   // The fill counter guards against matching the zero-initialised history,
   // which matters when PATTERN itself is all zeros.
   always_comb begin
      shift_next = {Shift_reg[PATTERN_W-2:0], D_in};
      fill_next  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      hit        = En && (fill_next == FILL_MAX) && (shift_next == PATTERN);
   end

   always_ff @(posedge CLK or negedge ClrN) begin
      if (!ClrN) begin
         Shift_reg <= '0;
         fill_q    <= '0;
         Valid     <= 1'b0;
         Match     <= 1'b0;
      end else begin
         Match <= hit;
         if (En) begin
            Shift_reg <= shift_next;
            fill_q    <= fill_next;
            Valid     <= (fill_next == FILL_MAX);
         end
      end
   end

   // Clear wins over a simultaneous increment; the counter never wraps.
   always_ff @(posedge CLK or negedge ClrN) begin
      if (!ClrN) begin
         Match_cnt <= '0;
      end else if (Clr_cnt) begin
         Match_cnt <= '0;
      end else if (hit && (Match_cnt != CNT_MAX)) begin
         Match_cnt <= Match_cnt + 1'b1;
      end
   end

endmodule
